rpn_sequencer: RTL and testbench

- Control FSM for the RPN calculator datapath.
- Turns a debounced, active-low enter key plus the switch word into stack operations.
- Drives a synchronous-read stack RAM and a combinational ALU, and holds the stack pointer and a cached top-of-stack for the HEX/LEDR display logic.
- Sits between the board I/O wrapper and the stack RAM/ALU.

---
 rtl/rpn_pkg.sv | 23 ++
 rtl/rpn_key_sync.sv | 36 +++
 rtl/rpn_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator control path: command codes,
// sequencer state encoding and default geometry.
package rpn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_ADD  = 2'b01;
    localparam logic [1:0] CMD_SUB  = 2'b10;
    localparam logic [1:0] CMD_MUL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_RD_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_EXEC = 3'd4,
        ST_WB   = 3'd5
    } state_e;

endpackage

// File: rtl/rpn_key_sync.sv
// Two-flop synchronizer for an active-low key with a one-cycle press pulse;
// resets to the released level so no spurious event follows reset.
module rpn_key_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic evt
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s2_prev_q, s2_prev_d;

    // Shift the key through the synchronizer and keep one cycle of history.
    always_comb begin
        s1_d      = key_n;
        s2_d      = s1_q;
        s2_prev_d = s2_q;
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s2_prev_q <= s2_prev_d;
        end
    end

    assign evt = s2_prev_q & ~s2_q;

endmodule

// File: rtl/rpn_sequencer.sv
// Control FSM for the RPN calculator: turns enter-key events and the switch
// word into stack RAM accesses and ALU operations, tracking sp and top.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enter_n,
    input  logic [DATA_W+1:0] sw,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic [DATA_W-1:0] top,
    output logic [ADDR_W:0]   depth,
    output logic              busy,
    output logic              done,
    output logic              err_under,
    output logic              err_full
);

    localparam logic [ADDR_W:0]   SP_ONE    = (ADDR_W+1)'(32'd1);
    localparam logic [ADDR_W:0]   SP_TWO    = (ADDR_W+1)'(32'd2);
    localparam logic [ADDR_W:0]   SP_FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(32'd2);

    logic              enter_evt_s;
    state_e            state_q, state_d;
    logic [ADDR_W:0]   sp_q, sp_d;
    logic [DATA_W-1:0] top_q, top_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              done_q, done_d;
    logic              err_under_q, err_under_d;
    logic              err_full_q, err_full_d;

    rpn_key_sync u_enter_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (enter_n),
        .evt   (enter_evt_s)
    );

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sp_q        <= '0;
            top_q       <= '0;
            opnd_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= 2'b00;
            done_q      <= 1'b0;
            err_under_q <= 1'b0;
            err_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            top_q       <= top_d;
            opnd_q      <= opnd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_q       <= cmd_d;
            done_q      <= done_d;
            err_under_q <= err_under_d;
            err_full_q  <= err_full_d;
        end
    end

    // Next-state and datapath update; events outside IDLE are dropped.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        top_d       = top_q;
        opnd_d      = opnd_q;
        a_d         = a_q;
        b_d         = b_q;
        cmd_d       = cmd_q;
        done_d      = 1'b0;
        err_under_d = err_under_q;
        err_full_d  = err_full_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_evt_s) begin
                    cmd_d       = sw[DATA_W+1:DATA_W];
                    opnd_d      = sw[DATA_W-1:0];
                    err_under_d = 1'b0;
                    err_full_d  = 1'b0;
                    if (sw[DATA_W+1:DATA_W] == CMD_PUSH) begin
                        if (sp_q == SP_FULL) begin
                            err_full_d = 1'b1;
                        end else begin
                            state_d = ST_PUSH;
                        end
                    end else begin
                        if (sp_q < SP_TWO) begin
                            err_under_d = 1'b1;
                        end else begin
                            state_d = ST_RD_B;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH: begin
                sp_d    = sp_q + SP_ONE;
                top_d   = opnd_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD_B: begin
                state_d = ST_RD_A;
            end
            ST_RD_A: begin
                b_d     = mem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                a_d     = mem_rdata;
                state_d = ST_WB;
            end
            ST_WB: begin
                sp_d    = sp_q - SP_ONE;
                top_d   = alu_y;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port drive; a write is suppressed in the cycle reset is asserted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_PUSH: begin
                mem_we    = ~reset;
                mem_addr  = sp_q[ADDR_W-1:0];
                mem_wdata = opnd_q;
            end
            ST_RD_B: begin
                mem_addr = sp_q[ADDR_W-1:0] - ADDR_ONE;
            end
            ST_RD_A: begin
                mem_addr = sp_q[ADDR_W-1:0] - ADDR_TWO;
            end
            ST_WB: begin
                mem_we    = ~reset;
                mem_addr  = sp_q[ADDR_W-1:0] - ADDR_TWO;
                mem_wdata = alu_y;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign alu_op    = cmd_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign top       = top_q;
    assign depth     = sp_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err_under = err_under_q;
    assign err_full  = err_full_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer: a stack RAM and ALU model surround the
// DUT, a queue-based stack model predicts completions and RAM writes.
module tb_rpn_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       enter_n  = 1'b1;
    logic [9:0] sw       = 10'd0;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [15:0] prod;
    logic [7:0] top;
    logic [3:0] depth;
    logic       busy, done, err_under, err_full;

    rpn_sequencer dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .enter_n   (enter_n),
        .sw        (sw),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .top       (top),
        .depth     (depth),
        .busy      (busy),
        .done      (done),
        .err_under (err_under),
        .err_full  (err_full)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [7:0] ram [0:7];
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    assign prod = alu_a * alu_b;
    always_comb begin
        case (alu_op)
            2'd1:    alu_y = alu_a + alu_b;
            2'd2:    alu_y = alu_a - alu_b;
            2'd3:    alu_y = prod[7:0];
            default: alu_y = alu_a;
        endcase
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct { int top; int depth; int cyc; } done_exp_t;
    typedef struct { int addr; int data; } wr_exp_t;
    done_exp_t done_exp[$];
    wr_exp_t   wr_exp[$];
    int model[$];
    int errors = 0;
    int checks = 0;
    int done_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse and every RAM write is matched against the queues.
    always @(negedge CLOCK_50) begin : monitor
        done_exp_t e;
        wr_exp_t   w;
        if (done === 1'b1) begin
            done_count++;
            if (done_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = done_exp.pop_front();
                chk("done_top", top, e.top);
                chk("done_depth", depth, e.depth);
                chk("done_cycle", cyc, e.cyc);
                chk("done_errs", {err_under, err_full}, 0);
            end
        end
        if (mem_we === 1'b1) begin
            if (wr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%0d expected none (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                w = wr_exp.pop_front();
                chk("write_addr", mem_addr, w.addr);
                chk("write_data", mem_wdata, w.data);
            end
        end
    end

    int exp_under = 0;
    int exp_full  = 0;

    // Stack model: command accepted on posedge c+3, push done at c+4, op at c+7.
    task automatic model_apply(input logic [9:0] v, input int c);
        int cmd, op, a, b, r;
        cmd = int'(v[9:8]);
        op  = int'(v[7:0]);
        exp_under = 0;
        exp_full  = 0;
        if (cmd == 0) begin
            if (model.size() == 8) begin
                exp_full = 1;
            end else begin
                wr_exp.push_back('{addr: model.size(), data: op});
                model.push_back(op);
                done_exp.push_back('{top: op, depth: model.size(), cyc: c + 4});
            end
        end else begin
            if (model.size() < 2) begin
                exp_under = 1;
            end else begin
                b = model.pop_back();
                a = model.pop_back();
                if (cmd == 1)      r = (a + b) & 255;
                else if (cmd == 2) r = (a - b) & 255;
                else               r = (a * b) & 255;
                wr_exp.push_back('{addr: model.size(), data: r});
                model.push_back(r);
                done_exp.push_back('{top: r, depth: model.size(), cyc: c + 7});
            end
        end
    endtask

    task automatic check_state(input string tag);
        int exp_top;
        exp_top = (model.size() == 0) ? 0 : model[$];
        chk({tag, "_depth"}, depth, model.size());
        chk({tag, "_top"}, top, exp_top);
        chk({tag, "_err_under"}, err_under, exp_under);
        chk({tag, "_err_full"}, err_full, exp_full);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic issue(input logic [9:0] v, input int hold);
        int c;
        @(negedge CLOCK_50);
        c = cyc;
        sw = v;
        model_apply(v, c);
        enter_n = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        enter_n = 1'b1;
        while (cyc < c + hold + 9) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        model.delete();
        exp_under = 0;
        exp_full  = 0;
    endtask

    initial begin : stim
        int c, d0;
        logic [9:0] v;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        chk("rst_top", top, 0);
        chk("rst_depth", depth, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_under, err_full}, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);

        // push 9, push 5, add
        d0 = done_count;
        issue(10'h009, 1);
        issue(10'h005, 1);
        issue(10'h100, 1);
        check_state("add");
        chk("add_top_lit", top, 14);
        chk("add_ram0", ram[0], 14);
        chk("add_done_count", done_count - d0, 3);

        do_reset();
        issue(10'h009, 1); issue(10'h005, 2); issue(10'h200, 1);
        chk("sub_top_lit", top, 4);
        issue(10'h003, 1); issue(10'h005, 1); issue(10'h200, 3);
        chk("sub_wrap_lit", top, 8'hFE);
        issue(10'h014, 1); issue(10'h00D, 1); issue(10'h300, 1);
        chk("mul_top_lit", top, 8'h04);
        check_state("arith");

        // underflow then recovery
        do_reset();
        issue(10'h100, 1);
        check_state("under");
        chk("under_flag_lit", err_under, 1);
        issue(10'h007, 1);
        check_state("under_clr");

        // fill then overflow
        do_reset();
        for (int i = 1; i <= 8; i++) issue(10'(i), 1);
        check_state("fill");
        issue(10'h009, 1);
        check_state("full");
        chk("full_flag_lit", err_full, 1);

        // long hold is one event
        do_reset();
        issue(10'h002, 50);
        check_state("hold");
        issue(10'h003, 1);
        issue(10'h004, 1);
        // second press lands in RD_A and must be dropped
        @(negedge CLOCK_50);
        c = cyc;
        sw = 10'h100;
        model_apply(10'h100, c);
        enter_n = 1'b0;
        @(negedge CLOCK_50); enter_n = 1'b1;
        @(negedge CLOCK_50); enter_n = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        enter_n = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        check_state("busy_drop");

        // reset during EXEC aborts the op
        do_reset();
        issue(10'h009, 1);
        issue(10'h005, 1);
        @(negedge CLOCK_50);
        c = cyc;
        sw = 10'h100;
        enter_n = 1'b0;
        @(negedge CLOCK_50); enter_n = 1'b1;
        while (cyc < c + 5) @(negedge CLOCK_50);
        chk("exec_busy", busy, 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        model.delete();
        chk("abort_busy", busy, 0);
        chk("abort_depth", depth, 0);
        chk("abort_top", top, 0);
        repeat (6) @(negedge CLOCK_50);
        check_state("abort");

        // randomized commands
        do_reset();
        for (int n = 0; n < 80; n++) begin
            v[9:8] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) v[9:8] = 2'd0;
            v[7:0] = 8'($urandom_range(0, 255));
            issue(v, $urandom_range(1, 4));
            check_state("rand");
        end

        repeat (10) @(negedge CLOCK_50);
        chk("pending_done", done_exp.size(), 0);
        chk("pending_writes", wr_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
